// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, counter debounce FSM, press/release strobes.
// Optional auto-repeat of press strobes while held, enabled by defining AUTO_REPEAT_EN.
module button_conditioner #(
   parameter int DBN_CYCLES    = 1_000_000,
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic button_in,
   output logic button_out,
   output logic pulse,
   output logic rel_pulse
);

   localparam logic [1:0] ST_IDLE         = 2'd0;
   localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] ST_PRESSED      = 2'd2;
   localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

   localparam int CW = $clog2(DBN_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] DBN_LAST = CW'(DBN_CYCLES - 1);

   if (DBN_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
      $error("button_conditioner: all cycle parameters must be >= 2");
   end

   logic          s1_q, s2_q;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          button_out_q, button_out_d;
   logic          pulse_q, pulse_d;
   logic          rel_pulse_q, rel_pulse_d;
   logic          press_s, release_s;

   // Debounce FSM next-state; the counter only advances while the new level persists.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      button_out_d = button_out_q;
      press_s      = 1'b0;
      release_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (s2_q) begin
               state_d = ST_PRESS_WAIT;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end
         ST_PRESS_WAIT: begin
            if (!s2_q) begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == DBN_LAST) begin
               state_d      = ST_PRESSED;
               button_out_d = 1'b1;
               press_s      = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_PRESSED: begin
            if (!s2_q) begin
               state_d = ST_RELEASE_WAIT;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d   = cnt_q;
            end
         end
         ST_RELEASE_WAIT: begin
            if (s2_q) begin
               state_d = ST_PRESSED;
            end else if (cnt_q == DBN_LAST) begin
               state_d      = ST_IDLE;
               button_out_d = 1'b0;
               release_s    = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            cnt_d        = CNT_ZERO;
            button_out_d = 1'b0;
         end
      endcase
   end

`ifdef AUTO_REPEAT_EN
   localparam int HW = $clog2((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES) + 1;
   localparam logic [HW-1:0] H_ZERO    = HW'(0);
   localparam logic [HW-1:0] H_ONE     = HW'(1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

   logic [HW-1:0] hcnt_q, hcnt_d;
   logic          hphase_q, hphase_d;
   logic          repeat_s;

   // Hold timer: first interval is HOLD_CYCLES, then REPEAT_CYCLES, until release is accepted.
   always_comb begin
      hcnt_d   = hcnt_q;
      hphase_d = hphase_q;
      repeat_s = 1'b0;
      if (press_s) begin
         hcnt_d   = H_ZERO;
         hphase_d = 1'b0;
      end else if (state_q == ST_PRESSED || state_q == ST_RELEASE_WAIT) begin
         if (hcnt_q == (hphase_q ? REP_LAST : HOLD_LAST)) begin
            repeat_s = 1'b1;
            hcnt_d   = H_ZERO;
            hphase_d = 1'b1;
         end else begin
            hcnt_d = hcnt_q + H_ONE;
         end
      end else begin
         hcnt_d   = H_ZERO;
         hphase_d = 1'b0;
      end
   end

   // Hold timer registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hcnt_q   <= H_ZERO;
         hphase_q <= 1'b0;
      end else begin
         hcnt_q   <= hcnt_d;
         hphase_q <= hphase_d;
      end
   end

   // A repeat landing on the release-acceptance cycle is dropped.
   assign pulse_d = press_s | (repeat_s & ~release_s);
`else
   assign pulse_d = press_s;
`endif

   assign rel_pulse_d = release_s;

   // Synchronizer, FSM state and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         state_q      <= ST_IDLE;
         cnt_q        <= CNT_ZERO;
         button_out_q <= 1'b0;
         pulse_q      <= 1'b0;
         rel_pulse_q  <= 1'b0;
      end else begin
         s1_q         <= button_in;
         s2_q         <= s1_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         button_out_q <= button_out_d;
         pulse_q      <= pulse_d;
         rel_pulse_q  <= rel_pulse_d;
      end
   end

   assign button_out = button_out_q;
   assign pulse      = pulse_q;
   assign rel_pulse  = rel_pulse_q;

endmodule
